// File: rtl/game_ctrl_pkg.sv
// Shared constants for the dino game pipeline: game_state encodings, window size,
// BCD digit sizing and a most-significant-digit-first BCD comparator.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    GAME_INIT  = 2'd0,
    GAME_START = 2'd1,
    GAME_END   = 2'd2,
    GAME_RESET = 2'd3
  } game_state_e;

  localparam int WINDOW_WIDTH  = 640;
  localparam int WINDOW_HEIGHT = 480;

  localparam int BCD_W        = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = BCD_W * SCORE_DIGITS;

  // True when a > b, deciding on the first differing digit from the top.
  function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
        gt   = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// Combinational 4-digit BCD incrementer: saturates at 9999 and flags an increment
// that rolls the low two digits over to 00.
module bcd_counter4
  import game_ctrl_pkg::*;
(
  input  logic [SCORE_W-1:0] value,
  input  logic               inc,
  output logic [SCORE_W-1:0] value_next,
  output logic               low_pair_zero
);

  logic [SCORE_DIGITS-1:0] carry;

  assign carry[0] = inc && (value != 16'h9999);

  generate
    for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] digit;
      assign digit = value[gi*BCD_W +: BCD_W];
      assign value_next[gi*BCD_W +: BCD_W] =
        !carry[gi] ? digit : ((digit == 4'd9) ? 4'd0 : 4'(digit + 4'd1));
      if (gi < SCORE_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit == 4'd9);
      end
    end
  endgenerate

  assign low_pair_zero = carry[0] && (value_next[7:0] == 8'h00);

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: game_state FSM, game_clk scroll divider with speed-up, BCD score.
// Optional high score register is built when GAME_CTRL_HISCORE_EN is defined.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV_INIT = 250000,
  parameter int unsigned TICK_DIV_MIN  = 100000,
  parameter int unsigned DIV_STEP      = 10000,
  parameter int unsigned SCORE_DIV     = 10,
  parameter int unsigned RESET_HOLD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic        game_clk,
  output logic        game_tick,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  localparam int SUB_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [19:0]       P_INIT        = 20'(TICK_DIV_INIT);
  localparam logic [19:0]       P_MIN         = 20'(TICK_DIV_MIN);
  localparam logic [19:0]       P_STEP        = 20'(DIV_STEP);
  localparam logic [20:0]       MIN_PLUS_STEP = 21'(TICK_DIV_MIN) + 21'(DIV_STEP);
  localparam logic [SUB_W-1:0]  SUB_LAST      = SUB_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(RESET_HOLD - 1);

  game_state_e       state_reg, state_next;
  logic [19:0]       period_reg;
  logic [19:0]       period_cur_reg;
  logic [19:0]       div_cnt_reg, div_next;
  logic [SUB_W-1:0]  sub_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [15:0]       score_reg, score_inc;
  logic              game_clk_reg, game_clk_next;
  logic              game_tick_reg, game_tick_next;
  logic              wrap;
  logic              sub_wrap;
  logic              speed_up;
  logic              reset_entry;
  logic [19:0]       period_dec;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GAME_INIT:  if (start_btn) state_next = GAME_START;
      GAME_START: if (collision) state_next = GAME_END;
      GAME_END:   if (start_btn) state_next = GAME_RESET;
      GAME_RESET: if (hold_cnt_reg == HOLD_LAST) state_next = GAME_START;
      default:    state_next = GAME_INIT;
    endcase
  end

  // period_cur_reg is the period actually being counted; it only picks up a new
  // period_reg at a wrap so a speed-up never cuts the running period short.
  always_comb begin
    wrap           = (state_reg == GAME_START) && (div_cnt_reg == period_cur_reg - 20'd1);
    div_next       = 20'd0;
    if (state_next == GAME_START && state_reg == GAME_START && !wrap)
      div_next = div_cnt_reg + 20'd1;
    game_clk_next  = (state_next == GAME_START) && (div_next < (period_cur_reg >> 1));
    game_tick_next = wrap && (state_next == GAME_START);
    reset_entry    = (state_reg == GAME_END) && (state_next == GAME_RESET);
    sub_wrap       = game_tick_reg && (sub_cnt_reg == SUB_LAST);
    period_dec     = ({1'b0, period_reg} >= MIN_PLUS_STEP) ? (period_reg - P_STEP) : P_MIN;
  end

  bcd_counter4 u_score_inc (
    .value         (score_reg),
    .inc           (sub_wrap),
    .value_next    (score_inc),
    .low_pair_zero (speed_up)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= GAME_INIT;
      div_cnt_reg    <= 20'd0;
      game_clk_reg   <= 1'b0;
      game_tick_reg  <= 1'b0;
      score_reg      <= 16'h0000;
      sub_cnt_reg    <= '0;
      period_reg     <= P_INIT;
      period_cur_reg <= P_INIT;
      hold_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_next;
      game_clk_reg  <= game_clk_next;
      game_tick_reg <= game_tick_next;
      if (reset_entry) begin
        score_reg      <= 16'h0000;
        sub_cnt_reg    <= '0;
        period_reg     <= P_INIT;
        period_cur_reg <= P_INIT;
        hold_cnt_reg   <= '0;
      end else begin
        score_reg <= score_inc;
        if (game_tick_reg)
          sub_cnt_reg <= sub_wrap ? '0 : sub_cnt_reg + 1'b1;
        if (speed_up)
          period_reg <= period_dec;
        if (wrap)
          period_cur_reg <= period_reg;
        if (state_reg == GAME_RESET)
          hold_cnt_reg <= (state_next == GAME_RESET) ? hold_cnt_reg + 1'b1 : '0;
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hi_score_reg;

  // score_inc is the value score_reg takes at this edge, so a point earned in the
  // collision cycle still counts towards the best.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_score_reg <= 16'h0000;
    end else if (state_reg == GAME_START && state_next == GAME_END &&
                 bcd_gt(score_inc, hi_score_reg)) begin
      hi_score_reg <= score_inc;
    end
  end

  assign hi_score = hi_score_reg;
`else
  assign hi_score = 16'h0000;
`endif

  assign game_state = state_reg;
  assign game_clk   = game_clk_reg;
  assign game_tick  = game_tick_reg;
  assign score      = score_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with shortened timing; expected tick spacing and
// score come from an arithmetic model of the game rules.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  localparam int INIT  = 20;
  localparam int MINP  = 8;
  localparam int STEP  = 4;
  localparam int SDIV  = 2;
  localparam int HOLD  = 4;

  logic        clk;
  logic        rst;
  logic        start_btn;
  logic        collision;
  logic [1:0]  game_state;
  logic        game_clk;
  logic        game_tick;
  logic [15:0] score;
  logic [15:0] hi_score;

  game_ctrl #(
    .TICK_DIV_INIT (INIT),
    .TICK_DIV_MIN  (MINP),
    .DIV_STEP      (STEP),
    .SCORE_DIV     (SDIV),
    .RESET_HOLD    (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .collision  (collision),
    .game_state (game_state),
    .game_clk   (game_clk),
    .game_tick  (game_tick),
    .score      (score),
    .hi_score   (hi_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int ticks_seen = 0;
  int best      = 0;

  typedef struct {
    int          interval;
    logic [15:0] score;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_note(input string name);
    total_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: points, BCD, scroll period from the rules of the game.
  function automatic int pts(input int ticks);
    int p;
    p = ticks / SDIV;
    return (p > 9999) ? 9999 : p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int period_for(input int points);
    int p;
    p = INIT - STEP * (points / 100);
    return (p < MINP) ? MINP : p;
  endfunction

  // A speed-up earned at one tick applies from the wrap after the next one, so
  // the gap ending at tick k uses the score reached after tick k-2.
  task automatic push_game(input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.interval = (k == 1) ? INIT : period_for(pts(k - 2));
      e.score    = to_bcd(pts(k));
      sb.push_back(e);
    end
  endtask

  // Monitor: times each game_tick against the expected gap and game_clk duty.
  logic [1:0]  prev_state = 2'd0;
  int          ref_cycle  = 0;
  int          hi_cnt     = 0;
  logic        score_pend = 1'b0;
  logic [15:0] pend_score = 16'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      score_pend = 1'b0;
    end else begin
      if (score_pend) begin
        chk("score_after_tick", 32'(score), 32'(pend_score));
        score_pend = 1'b0;
      end
      if (game_state == GAME_START) begin
        if (prev_state != GAME_START) begin
          ref_cycle = cyc;
          hi_cnt    = 0;
        end
        if (game_tick) begin
          ticks_seen++;
          if (sb.size() == 0) begin
            fail_note("unexpected_tick");
          end else begin
            e = sb.pop_front();
            chk("tick_interval", 32'(cyc - ref_cycle), 32'(e.interval));
            chk("clk_high_cycles", 32'(hi_cnt), 32'(e.interval / 2));
            chk("clk_rise_at_tick", 32'(game_clk), 32'd1);
            pend_score = e.score;
            score_pend = 1'b1;
          end
          ref_cycle = cyc;
          hi_cnt    = 0;
        end
        if (game_clk) hi_cnt++;
      end
    end
    prev_state = game_state;
  end

  task automatic wait_ticks(input int base, input int n);
    int budget;
    budget = n * INIT + 200;
    while (ticks_seen < base + n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (ticks_seen < base + n) begin
      fail_note("tick_wait_timeout");
      sb.delete();
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic end_game(input int n);
    logic [15:0] s;
    s = to_bcd(pts(n));
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk); #1 collision = 1'b1; start_btn = 1'b1;
    @(posedge clk); #1 collision = 1'b0; start_btn = 1'b0;
    @(negedge clk);
    chk("end_state", 32'(game_state), 32'(GAME_END));
    chk("end_clk_low", 32'(game_clk), 32'd0);
    chk("end_score", 32'(score), 32'(s));
    collision = 1'b1;
    repeat (3) @(negedge clk);
    collision = 1'b0;
    chk("end_ignores_collision", 32'(game_state), 32'(GAME_END));
    chk("end_score_frozen", 32'(score), 32'(s));
    chk("end_no_tick", 32'({game_clk, game_tick}), 32'd0);
    if (pts(n) > best) best = pts(n);
`ifdef GAME_CTRL_HISCORE_EN
    chk("hi_score", 32'(hi_score), 32'(to_bcd(best)));
`else
    chk("hi_score", 32'(hi_score), 32'd0);
`endif
    $display("game over after %0d ticks: score %h hi_score %h", n, score, hi_score);
  endtask

  task automatic restart();
    int cnt;
    cnt = 0;
    @(posedge clk); #1 start_btn = 1'b1;
    @(posedge clk); #1 start_btn = 1'b0;
    @(negedge clk);
    chk("reset_score_cleared", 32'(score), 32'd0);
    while (game_state == GAME_RESET && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("reset_hold_cycles", 32'(cnt), 32'(HOLD));
    chk("restart_state", 32'(game_state), 32'(GAME_START));
    $display("restart: %0d cycles in RESET", cnt);
  endtask

  initial begin
    int n1, n2, base;
    rst = 1'b0; start_btn = 1'b0; collision = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(game_state), 32'(GAME_INIT));
    chk("rst_clk", 32'(game_clk), 32'd0);
    chk("rst_tick", 32'(game_tick), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_hi_score", 32'(hi_score), 32'd0);

    repeat ($urandom_range(2, 6)) begin
      @(posedge clk); #1 collision = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 collision = 1'b0;
    @(negedge clk);
    chk("init_ignores_collision", 32'(game_state), 32'(GAME_INIT));

    // Game 1: long enough to hit the period floor.
    n1 = 1000 + $urandom_range(0, 100);
    base = ticks_seen;
    push_game(n1);
    @(posedge clk); #1 start_btn = 1'b1;
    @(posedge clk); #1 start_btn = 1'b0;
    @(negedge clk);
    chk("start_state", 32'(game_state), 32'(GAME_START));
    $display("game 1 started, expecting %0d ticks", n1);
    wait_ticks(base, n1);
    end_game(n1);

    // Game 2: random length, so the best may or may not change.
    n2 = $urandom_range(20, 1300);
    base = ticks_seen;
    push_game(n2);
    restart();
    @(posedge clk); #1 start_btn = 1'b1;
    @(posedge clk); #1 start_btn = 1'b0;
    @(negedge clk);
    chk("start_ignores_btn", 32'(game_state), 32'(GAME_START));
    $display("game 2 started, expecting %0d ticks", n2);
    wait_ticks(base, n2);
    end_game(n2);

    // Game 3: asynchronous reset in the middle of play at score 0057.
    base = ticks_seen;
    push_game(114);
    restart();
    wait_ticks(base, 114);
    @(negedge clk);
    chk("pre_rst_score", 32'(score), 32'(to_bcd(pts(114))));
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(game_state), 32'(GAME_INIT));
    chk("async_rst_clk", 32'(game_clk), 32'd0);
    chk("async_rst_tick", 32'(game_tick), 32'd0);
    chk("async_rst_score", 32'(score), 32'd0);
    chk("async_rst_hi_score", 32'(hi_score), 32'd0);
    $display("async reset applied mid-game");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_state", 32'(game_state), 32'(GAME_INIT));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Upstream game-flow controller for the dino game.
- Owns the game_state FSM (INIT/START/END/RESET) and generates the game_clk scroll clock consumed by the background/cloud renderer and the sprite stages.
- Keeps a BCD score and an optional high score for the score-display stage.
- Shortens the game_clk period as the score grows, so scrolling speeds up.

Parameters:
- TICK_DIV_INIT, 250000: initial game_clk period in clk cycles (400 Hz at 100 MHz).
- TICK_DIV_MIN, 100000: floor for the game_clk period.
- DIV_STEP, 10000: period decrement applied at each speed-up.
- SCORE_DIV, 10: game ticks per score point.
- RESET_HOLD, 16: clk cycles spent in RESET before re-entering START.

Ports:
- clk, in, 1: system clock (100 MHz).
- rst, in, 1: asynchronous, active-low reset.
- start_btn, in, 1: one-cycle start/restart pulse, already debounced upstream.
- collision, in, 1: level from the sprite-overlap checker.
- game_state, out, 2: encoding 0 = INIT, 1 = START, 2 = END, 3 = RESET. Shared constants.
- game_clk, out, 1: registered square wave; low outside START.
- game_tick, out, 1: one-cycle pulse in the clk domain at each game_clk rising edge.
- score, out, 16: four BCD digits.
- hi_score, out, 16: four BCD digits; see Optional Feature.

Behaviour:
- Reset (rst = 0, asynchronous) forces all registers to these values, from any state including mid-game:
  - game_state = INIT, game_clk = 0, game_tick = 0.
  - score = 0, hi_score = 0.
  - period = TICK_DIV_INIT, div_cnt = 0, sub_cnt = 0, hold_cnt = 0.
- FSM, one transition per clk; all outputs are registered:
  - INIT: start_btn moves to START. collision is ignored.
  - START: collision moves to END. If collision and start_btn arrive in the same cycle, collision wins. start_btn alone is ignored.
  - END: start_btn moves to RESET. collision is ignored.
  - RESET: clears score, period, div_cnt and sub_cnt on entry. Holds for exactly RESET_HOLD cycles using hold_cnt, then moves to START. start_btn is ignored.
- Divider, START only:
  - div_cnt counts 0 .. period-1 and then wraps to 0.
  - game_clk is registered as (div_cnt < period/2), using integer division.
  - game_tick = 1 in the cycle where div_cnt wraps to 0, coincident with the game_clk rise.
  - Outside START, div_cnt is held at 0 and game_clk = 0. In END, game_clk falls on the first END cycle, which freezes downstream scrolling.
- Score:
  - sub_cnt counts game_ticks from 0 to SCORE_DIV-1.
  - On wrap, score increments by 1 in BCD, carrying digit-wise.
  - score saturates at 16'h9999.
- Speed-up:
  - Triggers when a score increment makes the low two digits 8'h00 (every 100 points).
  - period = max(period - DIV_STEP, TICK_DIV_MIN).
  - The new period takes effect at the next div_cnt wrap. It never truncates the current period.
- Widths:
  - period and div_cnt are 20 bits.
  - Parameters must satisfy TICK_DIV_MIN >= 2 and TICK_DIV_INIT <= 2^20 - 1.

Optional Feature:
- Macro: GAME_CTRL_HISCORE_EN.
- When defined:
  - On the START→END transition, hi_score is loaded with score if score > hi_score (BCD compare, most-significant digit first).
  - hi_score survives RESET and the game restart; only rst clears it.
- When undefined: hi_score is tied to 16'h0000 and the comparator is not built.

Decomposition:
- Shared package/header holds:
  - GAME_INIT, GAME_START, GAME_END, GAME_RESET (2-bit encodings).
  - WINDOW_WIDTH and WINDOW_HEIGHT.
  - The BCD-digit width constant.
- One sub-module, bcd_counter4: 4-digit BCD increment with saturation and a low-pair-zero flag. It is reusable by the score-display stage.

Test Plan (sim overrides: TICK_DIV_INIT = 20, TICK_DIV_MIN = 8, DIV_STEP = 4, SCORE_DIV = 2, RESET_HOLD = 4):
1. Release rst, pulse start_btn → game_state 0→1 on the next clk. game_clk is high 10 cycles, low 10 cycles. game_tick pulses every 20 cycles.
2. Run 200 game_ticks → score = 16'h0100. The period drops to 16 from the first wrap after the 99→100 increment.
3. Run on to score 16'h0400 → period is clamped at 8 and stays 8 at 16'h0500.
4. Assert collision and start_btn in the same START cycle → game_state = 2. game_clk = 0 on the next cycle. score is frozen.
5. Pulse start_btn in END → game_state = 3 for exactly 4 cycles, then 1. score = 0 and period = 20.
   - With GAME_CTRL_HISCORE_EN: hi_score keeps the prior best, e.g. 16'h0437.
   - Without it: hi_score stays 0.
6. Drive rst low mid-START with score 16'h0057 → all outputs return to reset values asynchronously, without waiting for a clk edge. hi_score = 0.
